// File: rtl/elastic_fork_pkg.sv
// Shared constants for the elastic token modules (fork, buffer and friends).
package elastic_fork_pkg;

    // Default token width and fan-out used across all elastic modules.
    localparam int FORK_DATA_WIDTH      = 32;
    localparam int FORK_NEIGHBOR_PE_NUM = 4;

    // Two-entry skid FIFO geometry.
    localparam int FIFO_DEPTH = 2;
    localparam int COUNT_W    = 2;

endpackage

// File: rtl/elastic_buffer.sv
// Two-entry elastic FIFO with valid/stop handshakes on both sides.
// stop_input depends only on the occupancy register and reset_n, so the
// producer never sees a combinational path from downstream backpressure.
module elastic_buffer
    import elastic_fork_pkg::*;
#(
    parameter int WIDTH = FORK_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_input,
    input  logic             valid_input,
    output logic             stop_input,
    output logic [WIDTH-1:0] data_output,
    output logic             valid_output,
    input  logic             stop_output
);

    logic [WIDTH-1:0]   mem [FIFO_DEPTH];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [COUNT_W-1:0] count;
    logic               push;
    logic               pop;

    // Full or held in reset blocks the producer; reset also hides any stale head.
    assign stop_input   = (count == COUNT_W'(FIFO_DEPTH)) | ~reset_n;
    assign valid_output = (count != '0) & reset_n;
    assign data_output  = mem[rd_ptr];

    assign push = valid_input & ~stop_input;
    assign pop  = valid_output & ~stop_output;

    // Occupancy and pointer bookkeeping; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + COUNT_W'(push) - COUNT_W'(pop);
        end
    end

    // Storage needs no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_input;
        end
    end

endmodule

// File: rtl/elastic_fork.sv
// Eager fork: one producer, NEIGHBOR_PE_NUM consumers. Each enabled output
// takes the head token independently; a done bit per output remembers who
// already has it so nobody receives a duplicate. The head retires once every
// enabled output has either taken it earlier or is taking it this cycle.
module elastic_fork
    import elastic_fork_pkg::*;
#(
    parameter int DATA_WIDTH      = FORK_DATA_WIDTH,
    parameter int NEIGHBOR_PE_NUM = FORK_NEIGHBOR_PE_NUM
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic [DATA_WIDTH-1:0]                       data_input,
    input  logic                                        valid_input,
    output logic                                        stop_input,
    output logic [NEIGHBOR_PE_NUM-1:0][DATA_WIDTH-1:0]  data_output,
    output logic [NEIGHBOR_PE_NUM-1:0]                  valid_output,
    input  logic [NEIGHBOR_PE_NUM-1:0]                  stop_output,
    input  logic [NEIGHBOR_PE_NUM-1:0]                  output_enable_mask
);

    logic [DATA_WIDTH-1:0]      head_data;
    logic                       head_valid;
    logic                       head_stop;
    logic                       retire;
    logic [NEIGHBOR_PE_NUM-1:0] done;
    logic [NEIGHBOR_PE_NUM-1:0] fire;

    elastic_buffer #(
        .WIDTH(DATA_WIDTH)
    ) u_buffer (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_input   (data_input),
        .valid_input  (valid_input),
        .stop_input   (stop_input),
        .data_output  (head_data),
        .valid_output (head_valid),
        .stop_output  (head_stop)
    );

    // Per-output valid, transfer and data fan-out of the head token.
    always_comb begin
        valid_output = '0;
        fire         = '0;
        data_output  = '0;
        for (int i = 0; i < NEIGHBOR_PE_NUM; i++) begin
            valid_output[i] = head_valid & output_enable_mask[i] & ~done[i];
            fire[i]         = valid_output[i] & ~stop_output[i];
            data_output[i]  = head_data;
        end
    end

    // A disabled output counts as satisfied, so an all-zero mask drains one token per cycle.
    assign retire    = head_valid & (&(~output_enable_mask | done | fire));
    assign head_stop = ~retire;

    // Remember which outputs already took the current head; clear when it retires.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done <= '0;
        end else if (retire) begin
            done <= '0;
        end else begin
            done <= done | fire;
        end
    end

endmodule

// File: tb/tb_elastic_fork.sv
// Directed-vector bench for elastic_fork plus a seeded random scoreboard run.
module tb_elastic_fork;

    localparam int DW = 32;
    localparam int N  = 4;

    typedef struct {
        logic          rn;
        logic          vi;
        logic [DW-1:0] din;
        logic [N-1:0]  so;
        logic          exp_si;
        logic [N-1:0]  exp_vo;
        logic [DW-1:0] exp_d;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [DW-1:0]       data_input;
    logic                valid_input;
    logic                stop_input;
    logic [N-1:0][DW-1:0] data_output;
    logic [N-1:0]        valid_output;
    logic [N-1:0]        stop_output;
    logic [N-1:0]        output_enable_mask;

    int n_checks = 0;
    int n_fail   = 0;
    int fire_cnt [N];

    always #5 clk = ~clk;

    elastic_fork #(
        .DATA_WIDTH      (DW),
        .NEIGHBOR_PE_NUM (N)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .data_input         (data_input),
        .valid_input        (valid_input),
        .stop_input         (stop_input),
        .data_output        (data_output),
        .valid_output       (valid_output),
        .stop_output        (stop_output),
        .output_enable_mask (output_enable_mask)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Drive one vector, check outputs mid-cycle, then advance one clock.
    task automatic run_vec(input string name, input int k, input vec_t v);
        reset_n     = v.rn;
        valid_input = v.vi;
        data_input  = v.din;
        stop_output = v.so;
        settle();
        check($sformatf("%s[%0d].stop_input", name, k), 64'(stop_input), 64'(v.exp_si));
        check($sformatf("%s[%0d].valid_output", name, k), 64'(valid_output), 64'(v.exp_vo));
        if (v.exp_vo != '0) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("%s[%0d].data%0d", name, k, i), 64'(data_output[i]), 64'(v.exp_d));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (valid_output[i] && !stop_output[i]) fire_cnt[i]++;
        end
        step();
    endtask

    vec_t t_stream [5] = '{
        '{1'b1, 1'b1, 32'h11, 4'h0, 1'b0, 4'h0, 32'h00},
        '{1'b1, 1'b1, 32'h22, 4'h0, 1'b0, 4'hF, 32'h11},
        '{1'b1, 1'b1, 32'h33, 4'h0, 1'b0, 4'hF, 32'h22},
        '{1'b1, 1'b0, 32'h00, 4'h0, 1'b0, 4'hF, 32'h33},
        '{1'b1, 1'b0, 32'h00, 4'h0, 1'b0, 4'h0, 32'h00}
    };

    vec_t t_partial [6] = '{
        '{1'b1, 1'b1, 32'hA5, 4'h0, 1'b0, 4'h0, 32'h00},
        '{1'b1, 1'b0, 32'h00, 4'h4, 1'b0, 4'hF, 32'hA5},
        '{1'b1, 1'b0, 32'h00, 4'h4, 1'b0, 4'h4, 32'hA5},
        '{1'b1, 1'b0, 32'h00, 4'h4, 1'b0, 4'h4, 32'hA5},
        '{1'b1, 1'b0, 32'h00, 4'h0, 1'b0, 4'h4, 32'hA5},
        '{1'b1, 1'b0, 32'h00, 4'h0, 1'b0, 4'h0, 32'h00}
    };

    vec_t t_full [8] = '{
        '{1'b1, 1'b1, 32'h01, 4'hF, 1'b0, 4'h0, 32'h00},
        '{1'b1, 1'b1, 32'h02, 4'hF, 1'b0, 4'h5, 32'h01},
        '{1'b1, 1'b1, 32'h03, 4'hF, 1'b1, 4'h5, 32'h01},
        '{1'b1, 1'b1, 32'h03, 4'hF, 1'b1, 4'h5, 32'h01},
        '{1'b1, 1'b1, 32'h03, 4'h0, 1'b1, 4'h5, 32'h01},
        '{1'b1, 1'b1, 32'h03, 4'h0, 1'b0, 4'h5, 32'h02},
        '{1'b1, 1'b0, 32'h00, 4'h0, 1'b0, 4'h5, 32'h03},
        '{1'b1, 1'b0, 32'h00, 4'h0, 1'b0, 4'h0, 32'h00}
    };

    vec_t t_nomask [6] = '{
        '{1'b1, 1'b1, 32'h61, 4'h0, 1'b0, 4'h0, 32'h00},
        '{1'b1, 1'b1, 32'h62, 4'h0, 1'b0, 4'h0, 32'h00},
        '{1'b1, 1'b1, 32'h63, 4'h0, 1'b0, 4'h0, 32'h00},
        '{1'b1, 1'b1, 32'h64, 4'h0, 1'b0, 4'h0, 32'h00},
        '{1'b1, 1'b1, 32'h65, 4'h0, 1'b0, 4'h0, 32'h00},
        '{1'b1, 1'b0, 32'h00, 4'h0, 1'b0, 4'h0, 32'h00}
    };

    vec_t t_reset [8] = '{
        '{1'b1, 1'b1, 32'hB1, 4'hF, 1'b0, 4'h0, 32'h00},
        '{1'b1, 1'b1, 32'hB2, 4'hF, 1'b0, 4'hF, 32'hB1},
        '{1'b1, 1'b0, 32'h00, 4'hC, 1'b1, 4'hF, 32'hB1},
        '{1'b1, 1'b0, 32'h00, 4'hF, 1'b1, 4'hC, 32'hB1},
        '{1'b0, 1'b1, 32'h77, 4'hF, 1'b1, 4'h0, 32'h00},
        '{1'b1, 1'b1, 32'h5A, 4'h0, 1'b0, 4'h0, 32'h00},
        '{1'b1, 1'b0, 32'h00, 4'h0, 1'b0, 4'hF, 32'h5A},
        '{1'b1, 1'b0, 32'h00, 4'h0, 1'b0, 4'h0, 32'h00}
    };

    logic [DW-1:0] exp_q [N][$];

    initial begin
        logic [DW-1:0] next_tok;
        logic [DW-1:0] want;
        logic [N-1:0]  rmask;

        reset_n            = 1'b0;
        valid_input        = 1'b0;
        data_input         = '0;
        stop_output        = '0;
        output_enable_mask = 4'hF;
        step();
        step();
        settle();
        check("rst.stop_input", 64'(stop_input), 64'(1));
        check("rst.valid_output", 64'(valid_output), 64'(0));
        reset_n = 1'b1;
        settle();
        check("rel.stop_input", 64'(stop_input), 64'(0));
        check("rel.valid_output", 64'(valid_output), 64'(0));
        step();

        output_enable_mask = 4'hF;
        for (int k = 0; k < 5; k++) run_vec("stream", k, t_stream[k]);

        for (int i = 0; i < N; i++) fire_cnt[i] = 0;
        for (int k = 0; k < 6; k++) run_vec("partial", k, t_partial[k]);
        for (int i = 0; i < N; i++) begin
            check($sformatf("partial.fire_count%0d", i), 64'(fire_cnt[i]), 64'(1));
        end

        output_enable_mask = 4'h5;
        for (int k = 0; k < 8; k++) run_vec("full", k, t_full[k]);

        output_enable_mask = 4'h0;
        for (int k = 0; k < 6; k++) run_vec("nomask", k, t_nomask[k]);

        output_enable_mask = 4'hF;
        for (int k = 0; k < 8; k++) run_vec("reset", k, t_reset[k]);

        // Random traffic against per-output expected-token queues.
        void'($urandom(32'd20240611));
        rmask              = 4'hB;
        output_enable_mask = rmask;
        next_tok           = 32'h1000;
        for (int c = 0; c < 3020; c++) begin
            if (c < 3000) begin
                valid_input = 1'($urandom_range(0, 1));
                stop_output = 4'($urandom_range(0, 15));
            end else begin
                valid_input = 1'b0;
                stop_output = '0;
            end
            data_input = next_tok;
            settle();
            check("rnd.masked_valid", 64'(valid_output & ~rmask), 64'(0));
            for (int i = 0; i < N; i++) begin
                if (valid_output[i] && !stop_output[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("rnd.extra_token%0d", i), 64'(data_output[i]), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        want = exp_q[i].pop_front();
                        check($sformatf("rnd.data%0d", i), 64'(data_output[i]), 64'(want));
                    end
                end
            end
            if (valid_input && !stop_input) begin
                for (int i = 0; i < N; i++) begin
                    if (rmask[i]) exp_q[i].push_back(next_tok);
                end
                next_tok = next_tok + 1;
            end
            step();
        end
        for (int i = 0; i < N; i++) begin
            check($sformatf("rnd.leftover%0d", i), 64'(exp_q[i].size()), 64'(0));
        end
        check("rnd.tokens_accepted_nonzero", 64'(next_tok > 32'h1100), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
